// File: rtl/csa_pkg.sv
// Shared encodings and elaboration helpers for the pipelined carry-select adder.
package csa_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int nblk(input int width, input int blk);
    return (blk > 0) ? width / blk : 0;
  endfunction

  // True when the width splits into whole blocks and the blocks split evenly into stages.
  function automatic bit params_ok(input int width, input int blk, input int stages);
    if (blk <= 0 || width <= 0 || stages < 1) return 1'b0;
    if (width % blk != 0) return 1'b0;
    if (stages > width / blk) return 1'b0;
    return ((width / blk) % stages) == 0;
  endfunction

endpackage

// File: rtl/csa_block.sv
// BLK-bit dual adder: both carry-in hypotheses are computed so the carry only drives a select.
module csa_block #(
  parameter int BLK = 8
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  output logic [BLK-1:0] sum0,
  output logic [BLK-1:0] sum1,
  output logic           c0,
  output logic           c1
);

  assign {c0, sum0} = {1'b0, a} + {1'b0, b};
  assign {c1, sum1} = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, 1'b1};

endmodule

// File: rtl/csa_pipe.sv
// Pipelined carry-select adder/subtractor with valid/ready handshake; the pipe stalls as one unit.
module csa_pipe
  import csa_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int BLK    = 8,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int NBLK = nblk(WIDTH, BLK);
  localparam int BPS  = (STAGES > 0) ? NBLK / STAGES : 1;

  if (!params_ok(WIDTH, BLK, STAGES)) begin : g_bad_params
    $error("csa_pipe: illegal WIDTH/BLK/STAGES combination");
  end

  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // Per-stage register: low bits hold resolved sum, high bits still hold operand A.
  logic             v_reg  [STAGES];
  logic [WIDTH-1:0] x_reg  [STAGES];
  logic [WIDTH-1:0] y_reg  [STAGES];
  logic             c_reg  [STAGES];
  logic             am_reg [STAGES];
  logic             bm_reg [STAGES];

  logic             v_in   [STAGES];
  logic [WIDTH-1:0] x_in   [STAGES];
  logic [WIDTH-1:0] y_in   [STAGES];
  logic             c_in   [STAGES];
  logic             am_in  [STAGES];
  logic             bm_in  [STAGES];

  logic [WIDTH-1:0] x_next [STAGES];
  logic             c_next [STAGES];

  logic [BLK-1:0]   sum0_w [NBLK];
  logic [BLK-1:0]   sum1_w [NBLK];
  logic             c0_w   [NBLK];
  logic             c1_w   [NBLK];

  assign b_eff    = (op == OP_SUB) ? ~b : b;
  assign c_eff    = (op == OP_SUB) ? 1'b1 : ci;
  assign in_ready = !(out_valid && !out_ready);

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage_in
    if (gi == 0) begin : g_head
      assign v_in[gi]  = in_valid;
      assign x_in[gi]  = a;
      assign y_in[gi]  = b_eff;
      assign c_in[gi]  = c_eff;
      assign am_in[gi] = a[WIDTH-1];
      assign bm_in[gi] = b_eff[WIDTH-1];
    end else begin : g_link
      assign v_in[gi]  = v_reg[gi-1];
      assign x_in[gi]  = x_reg[gi-1];
      assign y_in[gi]  = y_reg[gi-1];
      assign c_in[gi]  = c_reg[gi-1];
      assign am_in[gi] = am_reg[gi-1];
      assign bm_in[gi] = bm_reg[gi-1];
    end
  end

  for (genvar gi = 0; gi < NBLK; gi++) begin : g_blk
    csa_block #(.BLK(BLK)) u_blk (
      .a    (x_in[gi / BPS][gi*BLK +: BLK]),
      .b    (y_in[gi / BPS][gi*BLK +: BLK]),
      .sum0 (sum0_w[gi]),
      .sum1 (sum1_w[gi]),
      .c0   (c0_w[gi]),
      .c1   (c1_w[gi])
    );
  end

  // Carry ripples through this stage's select muxes only.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      x_next[k] = x_in[k];
      c_next[k] = c_in[k];
      for (int j = 0; j < BPS; j++) begin
        x_next[k][(k*BPS+j)*BLK +: BLK] = c_next[k] ? sum1_w[k*BPS+j] : sum0_w[k*BPS+j];
        c_next[k] = c_next[k] ? c1_w[k*BPS+j] : c0_w[k*BPS+j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_reg[k]  <= 1'b0;
        x_reg[k]  <= '0;
        y_reg[k]  <= '0;
        c_reg[k]  <= 1'b0;
        am_reg[k] <= 1'b0;
        bm_reg[k] <= 1'b0;
      end
    end else if (in_ready) begin
      for (int k = 0; k < STAGES; k++) begin
        v_reg[k]  <= v_in[k];
        x_reg[k]  <= x_next[k];
        y_reg[k]  <= y_in[k];
        c_reg[k]  <= c_next[k];
        am_reg[k] <= am_in[k];
        bm_reg[k] <= bm_in[k];
      end
    end
  end

  assign out_valid = v_reg[STAGES-1];
  assign s         = x_reg[STAGES-1];
  assign co        = c_reg[STAGES-1];
  assign ovf       = (am_reg[STAGES-1] == bm_reg[STAGES-1]) &&
                     (x_reg[STAGES-1][WIDTH-1] != am_reg[STAGES-1]);

endmodule

// File: tb/tb_csa_pipe.sv
// Directed and randomised checks of csa_pipe at the default and two swept parameter sets.
module tb_csa_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default instance (64/8/4)
  logic        in_valid, in_ready, ci, op, out_valid, out_ready, co, ovf;
  logic [63:0] a, b, s;

  // Swept instances
  logic        v32, r32, ci32, op32, ov32, or32, co32, ovf32;
  logic [31:0] a32, b32, s32;
  logic        v16, r16, ci16, op16, ov16, or16, co16, ovf16;
  logic [15:0] a16, b16, s16;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  csa_pipe #(.WIDTH(64), .BLK(8), .STAGES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .ci(ci), .op(op), .out_valid(out_valid), .out_ready(out_ready), .s(s), .co(co), .ovf(ovf)
  );

  csa_pipe #(.WIDTH(32), .BLK(4), .STAGES(8)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(r32), .a(a32), .b(b32),
    .ci(ci32), .op(op32), .out_valid(ov32), .out_ready(or32), .s(s32), .co(co32), .ovf(ovf32)
  );

  csa_pipe #(.WIDTH(16), .BLK(16), .STAGES(1)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16), .a(a16), .b(b16),
    .ci(ci16), .op(op16), .out_valid(ov16), .out_ready(or16), .s(s16), .co(co16), .ovf(ovf16)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: returns {ovf, co, s} for a given width (s masked to width).
  function automatic logic [65:0] ref_model(input logic [63:0] ra, input logic [63:0] rb,
                                           input logic rci, input logic rop, input int w);
    logic [63:0] mask, bb, rs;
    logic [64:0] full;
    logic        rco, rovf;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    bb   = (rop ? ~rb : rb) & mask;
    full = {1'b0, ra & mask} + {1'b0, bb} + {64'd0, (rop ? 1'b1 : rci)};
    rs   = full[63:0] & mask;
    rco  = full[w];
    rovf = (ra[w-1] == bb[w-1]) && (rs[w-1] != ra[w-1]);
    return {rovf, rco, rs};
  endfunction

  // Issue one op into the idle 64-bit pipe and check latency and result.
  task automatic run_op(input string tag, input logic [63:0] ta, input logic [63:0] tb,
                        input logic tci, input logic top,
                        input logic [63:0] es, input logic eco, input logic eovf);
    int n;
    a = ta; b = tb; ci = tci; op = top; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, " lat"}, 64'(n), 64'd4);
    check({tag, " s"}, s, es);
    check({tag, " co"}, 64'(co), 64'(eco));
    check({tag, " ovf"}, 64'(ovf), 64'(eovf));
  endtask

  typedef struct {
    logic [65:0] exp;
    int          acc;
  } sb_t;

  initial begin
    sb_t q32[$];
    sb_t q16[$];
    sb_t e;
    int  sent, recv, stall_start, n;
    logic [63:0] ra, rb;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; ci = 1'b0; op = 1'b0;
    v32 = 1'b0; or32 = 1'b1; a32 = '0; b32 = '0; ci32 = 1'b0; op32 = 1'b0;
    v16 = 1'b0; or16 = 1'b1; a16 = '0; b16 = '0; ci16 = 1'b0; op16 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst s", s, 64'd0);
    check("rst co", 64'(co), 64'd0);
    check("rst ovf", 64'(ovf), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd1);

    // Three back-to-back adds return on three consecutive cycles after latency 4.
    ci = 1'b0; op = 1'b0; in_valid = 1'b1;
    a = 64'hFFFF_FFFF_FFFF_FFF9; b = 64'd3; tick();
    a = 64'd75; b = 64'd4; tick();
    a = 64'd43; b = 64'd95; tick();
    in_valid = 1'b0;
    check("b2b early valid", 64'(out_valid), 64'd0);
    tick();
    check("b2b0 valid", 64'(out_valid), 64'd1);
    check("b2b0 s", s, 64'hFFFF_FFFF_FFFF_FFFC);
    check("b2b0 co", 64'(co), 64'd0);
    check("b2b0 ovf", 64'(ovf), 64'd0);
    tick();
    check("b2b1 valid", 64'(out_valid), 64'd1);
    check("b2b1 s", s, 64'd79);
    check("b2b1 co", 64'(co), 64'd0);
    tick();
    check("b2b2 valid", 64'(out_valid), 64'd1);
    check("b2b2 s", s, 64'd138);
    tick();
    check("b2b drained", 64'(out_valid), 64'd0);

    run_op("ovf max+1", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
           64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_op("carry ones+ci", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
    run_op("sub 10-3", 64'd10, 64'd3, 1'b1, 1'b1, 64'd7, 1'b1, 1'b0);
    run_op("sub 3-10", 64'd3, 64'd10, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 1'b0);
    tick();

    // Backpressure: 8 ops a=i, b=100, out_ready low for 5 cycles from first out_valid.
    sent = 0; recv = 0; stall_start = -1; n = 0;
    op = 1'b0; ci = 1'b0; b = 64'd100;
    while (recv < 8 && n < 60) begin
      if (out_valid && stall_start < 0) stall_start = n;
      out_ready = !(stall_start >= 0 && n < stall_start + 5);
      in_valid  = (sent < 8);
      a         = 64'(sent);
      #1;
      if (!out_ready) begin
        check("bp stall in_ready", 64'(in_ready), 64'd0);
        check("bp stall s", s, 64'd100);
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        check("bp result", s, 64'(100 + recv));
        recv++;
      end
      tick();
      n++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp count", 64'(recv), 64'd8);
    tick();
    check("bp no dup", 64'(out_valid), 64'd0);

    // Reset with three ops in flight.
    op = 1'b0; ci = 1'b0; b = 64'd0; in_valid = 1'b1;
    a = 64'd1; tick();
    a = 64'd2; tick();
    a = 64'd3; tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst flushed", 64'(out_valid), 64'd0);
    end
    run_op("post-rst op", 64'd500, 64'd5, 1'b0, 1'b0, 64'd505, 1'b0, 1'b0);
    tick();

    // Random sweep on the 32/4/8 and 16/16/1 instances.
    n = 0;
    while ((n < 40 || q32.size() > 0 || q16.size() > 0) && n < 200) begin
      if (ov32) begin
        if (q32.size() == 0) check("w32 spurious", 64'd1, 64'd0);
        else begin
          e = q32.pop_front();
          check("w32 lat", 64'(cyc - e.acc), 64'd8);
          check("w32 res", {ovf32, co32, s32}, 64'(e.exp[33:0] | (e.exp[65:64] << 32)));
        end
      end
      if (ov16) begin
        if (q16.size() == 0) check("w16 spurious", 64'd1, 64'd0);
        else begin
          e = q16.pop_front();
          check("w16 lat", 64'(cyc - e.acc), 64'd1);
          check("w16 res", {ovf16, co16, s16}, 64'(e.exp[15:0] | (e.exp[65:64] << 16)));
        end
      end
      v32 = (n < 40); a32 = $urandom; b32 = $urandom; ci32 = $urandom_range(1); op32 = $urandom_range(1);
      v16 = (n < 40); a16 = 16'($urandom); b16 = 16'($urandom); ci16 = $urandom_range(1); op16 = $urandom_range(1);
      if (n == 0) begin a32 = 32'h7FFF_FFFF; b32 = 32'h1; op32 = 1'b0; ci32 = 1'b0; end
      if (n == 1) begin a16 = 16'h8000; b16 = 16'h1; op16 = 1'b1; end
      #1;
      if (v32 && r32) begin
        ra = 64'(a32); rb = 64'(b32);
        e.exp = ref_model(ra, rb, ci32, op32, 32);
        e.acc = cyc;
        q32.push_back(e);
      end
      if (v16 && r16) begin
        ra = 64'(a16); rb = 64'(b16);
        e.exp = ref_model(ra, rb, ci16, op16, 16);
        e.acc = cyc;
        q16.push_back(e);
      end
      tick();
      n++;
    end
    v32 = 1'b0; v16 = 1'b0;
    check("sweep drained", 64'(q32.size() + q16.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
